// File: rtl/tlb_pkg.sv
// Shared encodings for the TLB miss page walker.
// PTE field positions and walker state names.
package tlb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } walk_state_e;

   localparam int PTE_V     = 0;
   localparam int PTE_L     = 1;
   localparam int PTE_SHIFT = 3;

endpackage

// File: rtl/pte_decode.sv
// Classifies one PTE against the current walk level.
// Leaves are legal only at the last level; no superpages.
module pte_decode
   import tlb_pkg::*;
#(
   parameter int SADDR = 64,
   parameter int SPAGE = 12,
   parameter int SPTE  = 64
) (
   input  logic [SPTE-1:0]        pte_i,
   input  logic                   last_i,
   output logic [SADDR-SPAGE-1:0] next_frame_o,
   output logic                   is_leaf_ok_o,
   output logic                   is_fault_o
);

   logic v;
   logic l;
   logic unused_pte;

   assign v            = pte_i[PTE_V];
   assign l            = pte_i[PTE_L];
   assign next_frame_o = pte_i[SADDR-1:SPAGE];
   assign is_leaf_ok_o = v & l & last_i;
   assign is_fault_o   = ~v | (l ^ last_i);
   assign unused_pte   = ^pte_i;

endmodule

// File: rtl/tlb_page_walker.sv
// Single-outstanding radix page table walker on the TLB miss path.
// Returns {frame, offset} or a fault, held until the TLB consumes it.
module tlb_page_walker
   import tlb_pkg::*;
#(
   parameter int SADDR  = 64,
   parameter int SPAGE  = 12,
   parameter int SPCID  = 12,
   parameter int NLEVEL = 3,
   parameter int SIDX   = 9,
   parameter int SPTE   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SADDR-1:0] req_va,
   input  logic [SPCID-1:0] req_pcid,
   input  logic [SADDR-1:0] root_pa,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic [SADDR-1:0] mem_addr,
   input  logic             mem_resp_valid,
   input  logic [SPTE-1:0]  mem_resp_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [SADDR-1:0] resp_pa,
   output logic [SPCID-1:0] resp_pcid,
   output logic             resp_fault
);

   localparam int LW   = (NLEVEL > 1) ? $clog2(NLEVEL) : 1;
   localparam int SVA  = SPAGE + NLEVEL * SIDX;
   localparam int SFRM = SADDR - SPAGE;
   localparam logic [LW-1:0] LAST = LW'(NLEVEL - 1);

   walk_state_e      state_q, state_d;
   logic [LW-1:0]    level_q, level_d;
   logic [SVA-1:0]   va_q, va_d;
   logic [SPCID-1:0] pcid_q, pcid_d;
   logic [SFRM-1:0]  frame_q, frame_d;
   logic [SADDR-1:0] pa_q, pa_d;
   logic             fault_q, fault_d;

   logic [SIDX-1:0]  idx;
   logic [SADDR-1:0] pte_addr;
   logic [SFRM-1:0]  next_frame;
   logic             is_last;
   logic             leaf_ok;
   logic             pte_fault;
   logic             unused_in;

   assign unused_in = ^{root_pa, req_va};
   assign is_last   = (level_q == LAST);

   pte_decode #(
      .SADDR (SADDR),
      .SPAGE (SPAGE),
      .SPTE  (SPTE)
   ) u_dec (
      .pte_i        (mem_resp_data),
      .last_i       (is_last),
      .next_frame_o (next_frame),
      .is_leaf_ok_o (leaf_ok),
      .is_fault_o   (pte_fault)
   );

   // Level 0 consumes the most significant index field.
   always_comb begin
      idx = '0;
      for (int k = 0; k < NLEVEL; k++) begin
         if (level_q == LW'(k))
            idx = va_q[SPAGE+SIDX*(NLEVEL-k)-1 -: SIDX];
      end
   end

   assign pte_addr = {frame_q, {SPAGE{1'b0}}}
                   | (SADDR'(idx) << PTE_SHIFT);

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      va_d          = va_q;
      pcid_d        = pcid_q;
      frame_d       = frame_q;
      pa_d          = pa_q;
      fault_d       = fault_q;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      resp_valid    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               va_d    = req_va[SVA-1:0];
               pcid_d  = req_pcid;
               frame_d = root_pa[SADDR-1:SPAGE];
               level_d = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               if (pte_fault) begin
                  fault_d = 1'b1;
                  pa_d    = '0;
                  state_d = ST_RESP;
               end else if (leaf_ok) begin
                  fault_d = 1'b0;
                  pa_d    = {next_frame, va_q[SPAGE-1:0]};
                  state_d = ST_RESP;
               end else begin
                  frame_d = next_frame;
                  level_d = level_q + 1'b1;
                  state_d = ST_REQ;
               end
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         level_q <= '0;
         va_q    <= '0;
         pcid_q  <= '0;
         frame_q <= '0;
         pa_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         va_q    <= va_d;
         pcid_q  <= pcid_d;
         frame_q <= frame_d;
         pa_q    <= pa_d;
         fault_q <= fault_d;
      end
   end

   // Result fields read as zero whenever no result is offered.
   assign mem_addr   = mem_req_valid ? pte_addr : '0;
   assign resp_pa    = resp_valid ? pa_q : '0;
   assign resp_pcid  = resp_valid ? pcid_q : '0;
   assign resp_fault = resp_valid & fault_q;

   a_level_max: assert property (
      @(posedge clk) disable iff (!rst_n)
      level_q <= LAST);

   a_addr_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (mem_req_valid && !mem_req_ready)
      |=> (mem_req_valid && $stable(mem_addr)));

   a_resp_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (resp_valid && !resp_ready)
      |=> (resp_valid && $stable(resp_pa)
           && $stable(resp_fault)));

endmodule

// File: tb/tb_tlb_page_walker.sv
// Directed bench for tlb_page_walker with a scripted PTE responder.
module tb_tlb_page_walker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_va;
   logic [11:0] req_pcid;
   logic [63:0] root_pa;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_pa;
   logic [11:0] resp_pcid;
   logic        resp_fault;

   int checks = 0;
   int passed = 0;

   logic [63:0] pte_tab [8];
   logic [63:0] addr_log [64];
   int nreq = 0;
   int base = 0;
   int lim = 8;
   int stray_req = 0;
   int stray_done = 0;

   always #5 clk = ~clk;

   tlb_page_walker dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_va         (req_va),
      .req_pcid       (req_pcid),
      .root_pa        (root_pa),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_pa        (resp_pa),
      .resp_pcid      (resp_pcid),
      .resp_fault     (resp_fault)
   );

   initial begin
      logic        hs;
      logic [63:0] a;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         hs = mem_req_valid && mem_req_ready && rst_n;
         a  = mem_addr;
         @(posedge clk);
         #1;
         mem_resp_valid = 1'b0;
         if (stray_req != stray_done) begin
            stray_done++;
            mem_resp_data  = 64'h3001;
            mem_resp_valid = 1'b1;
         end else if (hs && (nreq - base) < lim) begin
            addr_log[nreq - base] = a;
            mem_resp_data  = pte_tab[nreq - base];
            mem_resp_valid = 1'b1;
            nreq++;
         end else if (hs) begin
            nreq++;
         end
      end
   end

   task automatic start_walk(input logic [63:0] va);
      int n = 0;
      req_va    = va;
      req_pcid  = 12'h05A;
      root_pa   = 64'h1ABC;
      req_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 100);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!resp_valid && cyc < 200);
      checks++;
      if (!resp_valid)
         $display("FAIL resp_timeout: resp_valid=%b want 1", resp_valid);
      else
         passed++;
   endtask

   task automatic retire;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n         = 1'b0;
      req_valid     = 1'b0;
      req_va        = '0;
      req_pcid      = '0;
      root_pa       = '0;
      mem_req_ready = 1'b1;
      resp_ready    = 1'b1;
      #12;
      checks++;
      if (req_ready !== 1'b1)
         $display("FAIL rst_req_ready: got %b want 1", req_ready);
      else passed++;
      checks++;
      if ({mem_req_valid, resp_valid, resp_fault} !== 3'b000)
         $display("FAIL rst_valids: got %b want 000",
                  {mem_req_valid, resp_valid, resp_fault});
      else passed++;
      checks++;
      if ({mem_addr, resp_pa, resp_pcid} !== '0)
         $display("FAIL rst_data: addr %h pa %h pcid %h want 0",
                  mem_addr, resp_pa, resp_pcid);
      else passed++;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_walk_ok;
      int cyc;
      base = nreq; lim = 8;
      pte_tab[0] = 64'h2001;
      pte_tab[1] = 64'h3001;
      pte_tab[2] = 64'hABCDE003;
      start_walk(64'h40603ABC);
      wait_resp(cyc);
      checks++;
      if (cyc !== 7)
         $display("FAIL ok_latency: got %0d want 7", cyc);
      else passed++;
      checks++;
      if (resp_pa !== 64'hABCDEABC || resp_fault !== 1'b0)
         $display("FAIL ok_result: pa %h f %b want abcdeabc 0",
                  resp_pa, resp_fault);
      else passed++;
      checks++;
      if (resp_pcid !== 12'h05A)
         $display("FAIL ok_pcid: got %h want 05a", resp_pcid);
      else passed++;
      checks++;
      if (nreq - base !== 3 || addr_log[0] !== 64'h1008 ||
          addr_log[1] !== 64'h2018 || addr_log[2] !== 64'h3018)
         $display("FAIL ok_addrs: n %0d %h %h %h want 3 1008 2018 3018",
                  nreq - base, addr_log[0], addr_log[1], addr_log[2]);
      else passed++;
      retire();
   endtask

   task automatic run_fault(input int nexp, input int cexp);
      int cyc;
      start_walk(64'h40603ABC);
      wait_resp(cyc);
      checks++;
      if (resp_fault !== 1'b1 || resp_pa !== '0)
         $display("FAIL fault_result n%0d: f %b pa %h want 1 0",
                  nexp, resp_fault, resp_pa);
      else passed++;
      checks++;
      if (nreq - base !== nexp || cyc !== cexp)
         $display("FAIL fault_reads: n %0d cyc %0d want %0d %0d",
                  nreq - base, cyc, nexp, cexp);
      else passed++;
      retire();
   endtask

   task automatic test_invalid_pte;
      base = nreq; lim = 8;
      pte_tab[0] = 64'h2001;
      pte_tab[1] = 64'h3000;
      pte_tab[2] = 64'hABCDE003;
      run_fault(2, 5);
   endtask

   task automatic test_illegal_leaf;
      base = nreq; lim = 8;
      pte_tab[0] = 64'h2003;
      pte_tab[1] = 64'h3001;
      run_fault(1, 3);
   endtask

   task automatic test_last_nonleaf;
      base = nreq; lim = 8;
      pte_tab[0] = 64'h2001;
      pte_tab[1] = 64'h3001;
      pte_tab[2] = 64'h4001;
      run_fault(3, 7);
   endtask

   task automatic test_backpressure;
      int cyc;
      base = nreq; lim = 8;
      pte_tab[0] = 64'h2001;
      pte_tab[1] = 64'h3001;
      pte_tab[2] = 64'hABCDE003;
      mem_req_ready = 1'b0;
      resp_ready    = 1'b0;
      start_walk(64'h40603ABC);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1008)
            $display("FAIL bp_addr_hold: v %b a %h want 1 1008",
                     mem_req_valid, mem_addr);
         else passed++;
      end
      @(posedge clk);
      #1;
      mem_req_ready = 1'b1;
      wait_resp(cyc);
      @(posedge clk);
      #1;
      base = nreq;
      pte_tab[2] = 64'h77777003;
      req_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_pa !== 64'hABCDEABC ||
             req_ready !== 1'b0)
            $display("FAIL bp_resp_hold: v %b pa %h rdy %b",
                     resp_valid, resp_pa, req_ready);
         else passed++;
         @(posedge clk);
         #1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 ||
          resp_valid !== 1'b0)
         $display("FAIL bp_retire: rdy %b mv %b rv %b want 1 0 0",
                  req_ready, mem_req_valid, resp_valid);
      else passed++;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1008)
         $display("FAIL bp_new_accept: v %b a %h want 1 1008",
                  mem_req_valid, mem_addr);
      else passed++;
      wait_resp(cyc);
      checks++;
      if (resp_pa !== 64'h77777ABC || resp_fault !== 1'b0)
         $display("FAIL bp_second: pa %h f %b want 77777abc 0",
                  resp_pa, resp_fault);
      else passed++;
      retire();
   endtask

   task automatic test_reset_mid_walk;
      int n = 0;
      base = nreq; lim = 1;
      pte_tab[0] = 64'h2001;
      start_walk(64'h40603ABC);
      do begin
         @(negedge clk);
         n++;
      end while (!(mem_req_valid && mem_addr == 64'h2018) && n < 50);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 ||
          resp_valid !== 1'b0 || resp_fault !== 1'b0 ||
          mem_addr !== '0 || resp_pa !== '0 || resp_pcid !== '0)
         $display("FAIL mid_rst_outputs: rdy %b mv %b rv %b a %h",
                  req_ready, mem_req_valid, resp_valid, mem_addr);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      stray_req++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
             req_ready !== 1'b1)
            $display("FAIL mid_rst_stray: rv %b mv %b rdy %b",
                     resp_valid, mem_req_valid, req_ready);
         else passed++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      test_walk_ok();
      test_walk_ok();
   endtask

   initial begin
      test_reset();
      test_walk_ok();
      test_invalid_pte();
      test_illegal_leaf();
      test_last_nonleaf();
      test_backpressure();
      test_reset_mid_walk();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim did not finish");
      $fatal(1);
   end

endmodule
